// File: rtl/telemetry_fifo_writer_pkg.sv
// Shared types and constants for the telemetry frame writer.
package telemetry_fifo_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CSR_RD,
        ST_CSR_WAIT,
        ST_WRITE
    } state_t;

    localparam int unsigned FRAME_WORDS       = 4;
    localparam logic [2:0]  CSR_FILL_ADDR     = 3'd0;
    localparam logic [15:0] FRAME_TAG_DEFAULT = 16'hA55A;

    // One captured set of telemetry values.
    typedef struct packed {
        logic [15:0] temp;
        logic [15:0] temp2;
        logic [15:0] pw_fwd;
        logic [15:0] pw_rev;
        logic [15:0] iter;
    } snapshot_t;

endpackage

// File: rtl/telemetry_fifo_writer_if.sv
// Data and CSR ports of the FPGA-to-HPS FIFO as seen by the frame writer.
interface telemetry_fifo_writer_if;

    logic [31:0] fifo_writedata;
    logic        fifo_write;
    logic [2:0]  fifo_csr_address;
    logic        fifo_csr_read;
    logic [31:0] fifo_csr_readdata;
    logic        fifo_csr_write;
    logic [31:0] fifo_csr_writedata;

    modport master (
        output fifo_writedata, fifo_write,
        output fifo_csr_address, fifo_csr_read, fifo_csr_write, fifo_csr_writedata,
        input  fifo_csr_readdata
    );

    modport slave (
        input  fifo_writedata, fifo_write,
        input  fifo_csr_address, fifo_csr_read, fifo_csr_write, fifo_csr_writedata,
        output fifo_csr_readdata
    );

endinterface

// File: rtl/telemetry_checksum16.sv
// Seven-input modulo-2^16 adder producing the frame checksum.
module telemetry_checksum16 (
    input  logic [15:0] in0_i,
    input  logic [15:0] in1_i,
    input  logic [15:0] in2_i,
    input  logic [15:0] in3_i,
    input  logic [15:0] in4_i,
    input  logic [15:0] in5_i,
    input  logic [15:0] in6_i,
    output logic [15:0] sum_o
);

    // Carries out of bit 15 are simply discarded.
    assign sum_o = in0_i + in1_i + in2_i + in3_i + in4_i + in5_i + in6_i;

endmodule

// File: rtl/telemetry_fifo_writer.sv
// Frames telemetry snapshots into four 32-bit words and pushes them into the
// FPGA-to-HPS FIFO after checking its fill level; one trigger can wait as pending.
module telemetry_fifo_writer
    import telemetry_fifo_writer_pkg::*;
#(
    parameter int          FIFO_DEPTH = 256,
    parameter logic [15:0] FRAME_TAG  = FRAME_TAG_DEFAULT
) (
    input  logic                          clk_clk,
    input  logic                          reset_reset,
    input  logic                          enable,
    input  logic                          sample_valid,
    input  logic [15:0]                   temperature,
    input  logic [15:0]                   temperature2,
    input  logic [15:0]                   pw_forward,
    input  logic [15:0]                   pw_reversed,
    input  logic [15:0]                   iteration_number,
    telemetry_fifo_writer_if.master       fifo,
    output logic                          busy,
    output logic [15:0]                   frame_count,
    output logic [15:0]                   drop_count
);

    localparam logic [1:0] LAST_WORD = 2'(FRAME_WORDS - 1);

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    snapshot_t   snap_q, snap_d, pend_snap_q, pend_snap_d, in_snap;
    logic        pending_q, pending_d;
    logic [15:0] seq_q, seq_d, frame_q, frame_d, drop_q, drop_d;
    logic [15:0] chk;
    logic        trig, room_ok, can_start;
    logic [1:0]  drop_inc;
    logic [16:0] drop_sum;

    assign trig    = sample_valid && enable;
    assign in_snap = '{temp: temperature, temp2: temperature2, pw_fwd: pw_forward,
                       pw_rev: pw_reversed, iter: iteration_number};
    // Wide compare so a fill level above FIFO_DEPTH reads as "no room".
    assign room_ok = ({1'b0, fifo.fifo_csr_readdata} + 33'(FRAME_WORDS)) <= 33'(FIFO_DEPTH);

    telemetry_checksum16 u_chk (
        .in0_i (FRAME_TAG),
        .in1_i (seq_q),
        .in2_i (snap_q.temp),
        .in3_i (snap_q.temp2),
        .in4_i (snap_q.pw_fwd),
        .in5_i (snap_q.pw_rev),
        .in6_i (snap_q.iter),
        .sum_o (chk)
    );

    assign fifo.fifo_csr_write     = 1'b0;
    assign fifo.fifo_csr_writedata = '0;
    assign busy        = (state_q != ST_IDLE) || pending_q;
    assign frame_count = frame_q;
    assign drop_count  = drop_q;

    // Next-state, counter updates and FIFO/CSR outputs.
    always_comb begin
        state_d               = state_q;
        idx_d                 = idx_q;
        snap_d                = snap_q;
        pend_snap_d           = pend_snap_q;
        pending_d             = pending_q;
        seq_d                 = seq_q;
        frame_d               = frame_q;
        drop_inc              = '0;
        can_start             = 1'b0;
        fifo.fifo_write       = 1'b0;
        fifo.fifo_writedata   = '0;
        fifo.fifo_csr_read    = 1'b0;
        fifo.fifo_csr_address = '0;

        unique case (state_q)
            ST_IDLE: can_start = 1'b1;
            ST_CSR_RD: begin
                fifo.fifo_csr_read    = 1'b1;
                fifo.fifo_csr_address = CSR_FILL_ADDR;
                state_d               = ST_CSR_WAIT;
            end
            ST_CSR_WAIT: begin
                if (room_ok) begin
                    state_d = ST_WRITE;
                    idx_d   = '0;
                end else begin
                    drop_inc  = drop_inc + 2'd1;
                    state_d   = ST_IDLE;
                    can_start = 1'b1;
                end
            end
            ST_WRITE: begin
                fifo.fifo_write = 1'b1;
                unique case (idx_q)
                    2'd0:    fifo.fifo_writedata = {FRAME_TAG, seq_q};
                    2'd1:    fifo.fifo_writedata = {snap_q.temp, snap_q.temp2};
                    2'd2:    fifo.fifo_writedata = {snap_q.pw_fwd, snap_q.pw_rev};
                    default: fifo.fifo_writedata = {snap_q.iter, chk};
                endcase
                if (idx_q == LAST_WORD) begin
                    seq_d     = seq_q + 16'd1;
                    frame_d   = (frame_q == '1) ? frame_q : frame_q + 16'd1;
                    state_d   = ST_IDLE;
                    can_start = 1'b1;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A trigger on the frame's last cycle starts the next frame directly;
        // that is the same timing as capturing it as pending and promoting it.
        if (can_start && pending_q) begin
            state_d   = ST_CSR_RD;
            snap_d    = pend_snap_q;
            pending_d = 1'b0;
        end
        if (trig) begin
            if (pending_q) begin
                drop_inc = drop_inc + 2'd1;
            end else if (can_start) begin
                state_d = ST_CSR_RD;
                snap_d  = in_snap;
            end else begin
                pending_d   = 1'b1;
                pend_snap_d = in_snap;
            end
        end

        drop_sum = {1'b0, drop_q} + 17'(drop_inc);
        drop_d   = drop_sum[16] ? '1 : drop_sum[15:0];
    end

    // State, snapshot and counter registers.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            snap_q      <= '0;
            pend_snap_q <= '0;
            pending_q   <= 1'b0;
            seq_q       <= '0;
            frame_q     <= '0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            snap_q      <= snap_d;
            pend_snap_q <= pend_snap_d;
            pending_q   <= pending_d;
            seq_q       <= seq_d;
            frame_q     <= frame_d;
            drop_q      <= drop_d;
        end
    end

endmodule

// File: tb/tb_telemetry_fifo_writer.sv
// Bench for telemetry_fifo_writer: directed scenarios plus a randomized stream
// checked against a job-scheduling model of the frame writer.
module tb_telemetry_fifo_writer;

    localparam int          DEPTH = 256;
    localparam logic [15:0] TAG   = 16'hA55A;
    localparam int          MAXN  = 600;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, sv;
    logic [15:0] t1, t2, pf, pr, it;
    logic        busy;
    logic [15:0] frame_count, drop_count;

    int checks = 0;
    int errors = 0;

    telemetry_fifo_writer_if fif ();

    telemetry_fifo_writer #(.FIFO_DEPTH(DEPTH), .FRAME_TAG(TAG)) dut (
        .clk_clk          (clk),
        .reset_reset      (rst),
        .enable           (en),
        .sample_valid     (sv),
        .temperature      (t1),
        .temperature2     (t2),
        .pw_forward       (pf),
        .pw_reversed      (pr),
        .iteration_number (it),
        .fifo             (fif),
        .busy             (busy),
        .frame_count      (frame_count),
        .drop_count       (drop_count)
    );

    always #5 clk = ~clk;

    // Stimulus per cycle
    logic        st_trig [MAXN];
    logic        st_en   [MAXN];
    logic [31:0] st_fill [MAXN];
    logic [15:0] st_d    [MAXN][5];
    // Observed per cycle
    logic        obs_wr [MAXN], obs_csr [MAXN], obs_cw [MAXN], obs_busy [MAXN];
    logic [31:0] obs_wd [MAXN], obs_cwd [MAXN];
    logic [2:0]  obs_addr [MAXN];
    logic [15:0] obs_frame [MAXN], obs_drop [MAXN];
    // Model expectations per cycle
    logic        exp_wr [MAXN], exp_csr [MAXN], exp_busy [MAXN];
    logic [31:0] exp_wd [MAXN];
    int          exp_frame [MAXN], exp_drop [MAXN], finc [MAXN], dinc [MAXN];
    int          m_end, m_seq;

    function automatic int chk16(input int seq, input logic [15:0] d [5]);
        int s = int'(TAG) + seq;
        for (int k = 0; k < 5; k++) s += int'(d[k]);
        return s % 65536;
    endfunction

    // A job started by a trigger at cycle s reads the fill level at s+2 and,
    // with room, writes its four words at s+3..s+6.
    function automatic void launch(input int s, input logic [15:0] d [5]);
        exp_csr[s+1] = 1'b1;
        if (int'(st_fill[s+2]) + 4 <= DEPTH && st_fill[s+2] < 32'h1000_0000) begin
            exp_wd[s+3] = {TAG, 16'(m_seq)};
            exp_wd[s+4] = {d[0], d[1]};
            exp_wd[s+5] = {d[2], d[3]};
            exp_wd[s+6] = {d[4], 16'(chk16(m_seq, d))};
            for (int k = 3; k <= 6; k++) exp_wr[s+k] = 1'b1;
            finc[s+6]++;
            m_seq = (m_seq + 1) % 65536;
            m_end = s + 6;
        end else begin
            dinc[s+2]++;
            m_end = s + 2;
        end
        for (int k = s + 1; k <= m_end; k++) exp_busy[k] = 1'b1;
    endfunction

    function automatic void build_model(input int n);
        logic        pend = 1'b0;
        logic        pb;
        logic [15:0] pd [5];
        int          v;
        m_end = -1;
        m_seq = 0;
        for (int t = 0; t < MAXN; t++) begin
            exp_wr[t] = 1'b0; exp_csr[t] = 1'b0; exp_busy[t] = 1'b0; exp_wd[t] = '0;
            finc[t] = 0; dinc[t] = 0;
        end
        for (int k = 0; k < 5; k++) pd[k] = '0;
        for (int t = 0; t < n; t++) begin
            pb = pend;
            if (pb && t == m_end) begin
                launch(t, pd);
                pend = 1'b0;
            end
            if (st_trig[t] && st_en[t]) begin
                if (pb) dinc[t]++;
                else if (t >= m_end) launch(t, st_d[t]);
                else begin
                    pend = 1'b1;
                    pd   = st_d[t];
                    for (int k = t + 1; k <= m_end; k++) exp_busy[k] = 1'b1;
                end
            end
        end
        exp_frame[0] = 0;
        exp_drop[0]  = 0;
        for (int t = 1; t < n; t++) begin
            v = exp_frame[t-1] + finc[t-1];
            exp_frame[t] = (v > 65535) ? 65535 : v;
            v = exp_drop[t-1] + dinc[t-1];
            exp_drop[t] = (v > 65535) ? 65535 : v;
        end
    endfunction

    task automatic clear_stim();
        for (int t = 0; t < MAXN; t++) begin
            st_trig[t] = 1'b0; st_en[t] = 1'b1; st_fill[t] = '0;
            for (int k = 0; k < 5; k++) st_d[t][k] = '0;
        end
    endtask

    task automatic set_trig(input int t, input logic [15:0] a, b, c, d, e);
        st_trig[t] = 1'b1;
        st_d[t][0] = a; st_d[t][1] = b; st_d[t][2] = c; st_d[t][3] = d; st_d[t][4] = e;
    endtask

    // Entered and left 1 ns after a rising edge; cycle t lies between edges t and t+1.
    task automatic run(input int n);
        for (int t = 0; t < n; t++) begin
            en = st_en[t]; sv = st_trig[t];
            t1 = st_d[t][0]; t2 = st_d[t][1]; pf = st_d[t][2]; pr = st_d[t][3]; it = st_d[t][4];
            fif.fifo_csr_readdata = st_fill[t];
            @(negedge clk);
            obs_wr[t] = fif.fifo_write;     obs_wd[t] = fif.fifo_writedata;
            obs_csr[t] = fif.fifo_csr_read; obs_addr[t] = fif.fifo_csr_address;
            obs_cw[t] = fif.fifo_csr_write; obs_cwd[t] = fif.fifo_csr_writedata;
            obs_busy[t] = busy; obs_frame[t] = frame_count; obs_drop[t] = drop_count;
            @(posedge clk);
            #1;
        end
        sv = 1'b0;
        en = 1'b1;
        fif.fifo_csr_readdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1; sv = 1'b0; en = 1'b1;
        t1 = '0; t2 = '0; pf = '0; pr = '0; it = '0;
        fif.fifo_csr_readdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [101:0] o;
        rst = 1'b1; sv = 1'b1; en = 1'b1; t1 = 16'h1234;
        fif.fifo_csr_readdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        o = {fif.fifo_write, fif.fifo_writedata, fif.fifo_csr_read, fif.fifo_csr_address,
             fif.fifo_csr_write, fif.fifo_csr_writedata, frame_count, drop_count};
        checks++;
        if (o !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got %h busy %b want 0", o, busy);
        end
        sv = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || frame_count !== 16'd0 || drop_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_release got busy %b fc %h dc %h want 0/0/0", busy, frame_count, drop_count);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_frame();
        logic [31:0] want [4];
        want[0] = 32'hA55A0000; want[1] = 32'h01000200; want[2] = 32'h00100020; want[3] = 32'h0005A88F;
        do_reset();
        clear_stim();
        set_trig(2, 16'h0100, 16'h0200, 16'h0010, 16'h0020, 16'h0005);
        run(14);
        checks++;
        if (obs_csr[3] !== 1'b1 || obs_addr[3] !== 3'd0 || obs_csr[2] !== 1'b0 || obs_csr[4] !== 1'b0) begin
            errors++;
            $display("FAIL single_csr got rd %b%b%b addr %0d want 010 addr 0",
                     obs_csr[2], obs_csr[3], obs_csr[4], obs_addr[3]);
        end
        checks++;
        if (obs_wr[4] !== 1'b0 || obs_wr[9] !== 1'b0 || obs_wd[9] !== 32'd0) begin
            errors++;
            $display("FAIL single_window got wr4 %b wr9 %b wd9 %h want 0 0 0", obs_wr[4], obs_wr[9], obs_wd[9]);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (obs_wr[5+k] !== 1'b1 || obs_wd[5+k] !== want[k]) begin
                errors++;
                $display("FAIL single_word%0d got %b/%h want 1/%h", k, obs_wr[5+k], obs_wd[5+k], want[k]);
            end
        end
        checks++;
        if (obs_frame[9] !== 16'd1 || obs_drop[13] !== 16'd0 || obs_busy[3] !== 1'b1 || obs_busy[9] !== 1'b0) begin
            errors++;
            $display("FAIL single_status got fc %h dc %h busy %b%b want 1 0 10",
                     obs_frame[9], obs_drop[13], obs_busy[3], obs_busy[9]);
        end
    endtask

    task automatic test_full_fifo();
        int nwr = 0;
        do_reset();
        clear_stim();
        set_trig(2, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555);
        st_fill[4] = 32'd253;
        set_trig(10, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005);
        st_fill[12] = 32'd252;
        run(22);
        for (int t = 0; t < 10; t++) nwr += int'(obs_wr[t]);
        checks++;
        if (nwr != 0 || obs_drop[5] !== 16'd1 || obs_busy[5] !== 1'b0) begin
            errors++;
            $display("FAIL full_drop got writes %0d dc %h busy %b want 0 1 0", nwr, obs_drop[5], obs_busy[5]);
        end
        checks++;
        if (obs_wr[13] !== 1'b1 || obs_wd[13] !== 32'hA55A0000) begin
            errors++;
            $display("FAIL full_next_header got %b/%h want 1/A55A0000", obs_wr[13], obs_wd[13]);
        end
        checks++;
        if (obs_frame[21] !== 16'd1 || obs_drop[21] !== 16'd1) begin
            errors++;
            $display("FAIL full_counts got fc %h dc %h want 1 1", obs_frame[21], obs_drop[21]);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] b [5];
        logic [31:0] want [4];
        b[0] = 16'hB001; b[1] = 16'hB002; b[2] = 16'hB003; b[3] = 16'hB004; b[4] = 16'hB005;
        do_reset();
        clear_stim();
        set_trig(2, 16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hA005);
        set_trig(4, b[0], b[1], b[2], b[3], b[4]);
        set_trig(6, 16'hC001, 16'hC002, 16'hC003, 16'hC004, 16'hC005);
        run(22);
        want[0] = {TAG, 16'h0001};
        want[1] = {b[0], b[1]};
        want[2] = {b[2], b[3]};
        want[3] = {b[4], 16'(chk16(1, b))};
        checks++;
        if (obs_wd[5] !== 32'hA55A0000 || obs_csr[9] !== 1'b1 || obs_wr[9] !== 1'b0 || obs_wr[10] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first got hdr %h csr9 %b wr9/10 %b%b want A55A0000 1 00",
                     obs_wd[5], obs_csr[9], obs_wr[9], obs_wr[10]);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (obs_wr[11+k] !== 1'b1 || obs_wd[11+k] !== want[k]) begin
                errors++;
                $display("FAIL b2b_word%0d got %b/%h want 1/%h", k, obs_wr[11+k], obs_wd[11+k], want[k]);
            end
        end
        checks++;
        if (obs_drop[7] !== 16'd1 || obs_drop[21] !== 16'd1 || obs_frame[21] !== 16'd2 || obs_busy[21] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_counts got dc %h/%h fc %h busy %b want 1/1 2 0",
                     obs_drop[7], obs_drop[21], obs_frame[21], obs_busy[21]);
        end
    endtask

    task automatic test_enable_off();
        int act = 0;
        do_reset();
        clear_stim();
        for (int t = 0; t < 12; t++) st_en[t] = 1'b0;
        set_trig(2, 16'h1, 16'h2, 16'h3, 16'h4, 16'h5);
        run(12);
        for (int t = 0; t < 12; t++) act += int'(obs_csr[t]) + int'(obs_wr[t]) + int'(obs_busy[t]);
        checks++;
        if (act != 0 || obs_frame[11] !== 16'd0 || obs_drop[11] !== 16'd0) begin
            errors++;
            $display("FAIL enable_off got activity %0d fc %h dc %h want 0 0 0", act, obs_frame[11], obs_drop[11]);
        end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        clear_stim();
        set_trig(2, 16'h0100, 16'h0200, 16'h0010, 16'h0020, 16'h0005);
        run(12);
        clear_stim();
        set_trig(2, 16'h0100, 16'h0200, 16'h0010, 16'h0020, 16'h0005);
        run(7);
        // Now 1 ns into the W2 cycle of the second frame.
        checks++;
        if (fif.fifo_write !== 1'b1 || frame_count !== 16'd1 || obs_wd[5] !== 32'hA55A0001) begin
            errors++;
            $display("FAIL midframe_before got wr %b fc %h hdr %h want 1 1 A55A0001",
                     fif.fifo_write, frame_count, obs_wd[5]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (fif.fifo_write !== 1'b0 || fif.fifo_writedata !== 32'd0 || frame_count !== 16'd0 ||
            drop_count !== 16'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midframe_reset got wr %b wd %h fc %h dc %h busy %b want all 0",
                     fif.fifo_write, fif.fifo_writedata, frame_count, drop_count, busy);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_stim();
        set_trig(2, 16'h0100, 16'h0200, 16'h0010, 16'h0020, 16'h0005);
        run(12);
        checks++;
        if (obs_wr[5] !== 1'b1 || obs_wd[5] !== 32'hA55A0000 || obs_frame[11] !== 16'd1) begin
            errors++;
            $display("FAIL midframe_after got %b/%h fc %h want 1/A55A0000 1", obs_wr[5], obs_wd[5], obs_frame[11]);
        end
    endtask

    task automatic test_random();
        logic [102:0] ev, ov;
        int r;
        int n = 480;
        do_reset();
        clear_stim();
        for (int t = 0; t < n; t++) begin
            st_trig[t] = (t < 460) && ($urandom_range(0, 3) == 0);
            st_en[t]   = ($urandom_range(0, 9) != 0);
            for (int k = 0; k < 5; k++) st_d[t][k] = 16'($urandom);
            r = int'($urandom_range(0, 9));
            if (r < 6)       st_fill[t] = $urandom_range(0, 200);
            else if (r == 6) st_fill[t] = 32'd252;
            else if (r == 7) st_fill[t] = 32'd253;
            else if (r == 8) st_fill[t] = 32'd256;
            else             st_fill[t] = $urandom_range(250, 300);
        end
        build_model(n);
        run(n);
        for (int t = 0; t < n; t++) begin
            ev = {exp_wr[t], exp_wd[t], exp_csr[t], 3'd0, 1'b0, 32'd0, exp_busy[t],
                  16'(exp_frame[t]), 16'(exp_drop[t])};
            ov = {obs_wr[t], obs_wd[t], obs_csr[t], obs_addr[t], obs_cw[t], obs_cwd[t], obs_busy[t],
                  obs_frame[t], obs_drop[t]};
            checks++;
            if (ov !== ev) begin
                errors++;
                $display("FAIL random_cycle%0d got %h want %h", t, ov, ev);
            end
        end
    endtask

    task automatic test_wrap();
        logic [15:0] d [5];
        d[0] = 16'h0100; d[1] = 16'h0200; d[2] = 16'h0010; d[3] = 16'h0020; d[4] = 16'h0005;
        do_reset();
        // Stand-in for 65535 completed frames.
        force dut.seq_q = 16'hFFFF;
        force dut.frame_q = 16'hFFFF;
        @(negedge clk);
        release dut.seq_q;
        release dut.frame_q;
        @(posedge clk);
        #1;
        clear_stim();
        set_trig(2, d[0], d[1], d[2], d[3], d[4]);
        set_trig(10, d[0], d[1], d[2], d[3], d[4]);
        run(20);
        checks++;
        if (obs_wd[5] !== 32'hA55AFFFF || obs_wd[8] !== {d[4], 16'(chk16(65535, d))}) begin
            errors++;
            $display("FAIL wrap_ffff got %h/%h want A55AFFFF/%h", obs_wd[5], obs_wd[8], {d[4], 16'(chk16(65535, d))});
        end
        checks++;
        if (obs_wd[13] !== 32'hA55A0000 || obs_wr[13] !== 1'b1) begin
            errors++;
            $display("FAIL wrap_zero got %b/%h want 1/A55A0000", obs_wr[13], obs_wd[13]);
        end
        checks++;
        if (obs_frame[0] !== 16'hFFFF || obs_frame[9] !== 16'hFFFF || obs_frame[19] !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_frame_sat got %h/%h/%h want FFFF", obs_frame[0], obs_frame[9], obs_frame[19]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_full_fifo();
        test_back_to_back();
        test_enable_off();
        test_reset_midframe();
        test_random();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
